// File: rtl/ram_fifo_ctrl.sv
// Pointer/flag controller that turns a 2**ADDR_W x 8 two-port RAM with registered
// read data into a synchronous FIFO; data bytes bypass this block entirely.
module ram_fifo_ctrl #(
  parameter int ADDR_W    = 4,
  parameter int AF_THRESH = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              clr_err,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] AF_CNT   = AF_THRESH[ADDR_W:0];

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              pop_acc;
  logic              push_acc;

  assign full        = (count == FULL_CNT);
  assign empty       = (count == '0);
  assign almost_full = (count >= AF_CNT);

  // A push into a full FIFO is only safe when a pop frees the slot in the same cycle;
  // there is no bypass path for a pop on an empty FIFO.
  assign pop_acc  = pop & ~empty;
  assign push_acc = push & (~full | pop_acc);

  assign ram_wen   = push_acc & ~reset;
  assign ram_waddr = wr_ptr;
  assign ram_raddr = rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_acc, pop_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      rd_valid <= pop_acc;
      // A new error in the same cycle as clr_err leaves the flag set.
      overflow  <= (overflow  & ~clr_err) | (push & ~push_acc);
      underflow <= (underflow & ~clr_err) | (pop  & ~pop_acc);
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl: a behavioural 16x8 RAM with registered read
// sits behind the controller so popped bytes can be compared against pushed ones.
module tb_ram_fifo_ctrl;

  logic       clk;
  logic       reset;
  logic       push;
  logic       pop;
  logic       clr_err;
  logic [7:0] din;
  logic       ram_wen;
  logic [3:0] ram_waddr;
  logic [3:0] ram_raddr;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  logic [7:0] mem [16];
  logic [7:0] data_out;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       rst, psh, pp, clr;
    logic [7:0] din;
    logic       wen;
    int         cnt, wa, ra;
    logic       rv, emp, ful, ovf, unf, chk;
    logic [7:0] dat;
  } vec_t;

  vec_t vecs [17];

  ram_fifo_ctrl #(.ADDR_W(4), .AF_THRESH(12)) dut (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .clr_err    (clr_err),
    .ram_wen    (ram_wen),
    .ram_waddr  (ram_waddr),
    .ram_raddr  (ram_raddr),
    .rd_valid   (rd_valid),
    .full       (full),
    .empty      (empty),
    .almost_full(almost_full),
    .count      (count),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-before-write RAM: a same-address write and read returns the old word.
  always @(posedge clk) begin
    if (ram_wen) mem[ram_waddr] <= din;
    data_out <= mem[ram_raddr];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs, checks the combinational write enable before the
  // edge, then returns just after the edge so registered outputs can be sampled.
  task automatic applyStimulus(input logic r, input logic p, input logic q, input logic c,
                               input logic [7:0] d, input logic exp_wen);
    reset = r; push = p; pop = q; clr_err = c; din = d;
    #2;
    checkOutput("ram_wen", ram_wen, exp_wen);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n_in;
    int n_out;
    reset = 1'b1; push = 1'b0; pop = 1'b0; clr_err = 1'b0; din = 8'h00;
    // rst psh pop clr din wen cnt wa ra rv emp ful ovf unf chk dat
    vecs[0]  = '{1'b1,1'b1,1'b1,1'b0,8'h00,1'b0,0,0,0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00};
    vecs[1]  = '{1'b0,1'b1,1'b0,1'b0,8'h70,1'b1,1,1,0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00};
    vecs[2]  = '{1'b0,1'b1,1'b0,1'b0,8'h01,1'b1,2,2,0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00};
    vecs[3]  = '{1'b0,1'b0,1'b1,1'b0,8'h00,1'b0,1,2,1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,8'h70};
    vecs[4]  = '{1'b0,1'b0,1'b1,1'b0,8'h00,1'b0,0,2,2,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,8'h01};
    vecs[5]  = '{1'b0,1'b0,1'b0,1'b0,8'h00,1'b0,0,2,2,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00};
    vecs[6]  = '{1'b0,1'b0,1'b1,1'b0,8'h00,1'b0,0,2,2,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,8'h00};
    vecs[7]  = '{1'b0,1'b1,1'b1,1'b0,8'h33,1'b1,1,3,2,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,8'h00};
    vecs[8]  = '{1'b0,1'b0,1'b0,1'b1,8'h00,1'b0,1,3,2,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00};
    vecs[9]  = '{1'b0,1'b1,1'b0,1'b0,8'h11,1'b1,2,4,2,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00};
    vecs[10] = '{1'b0,1'b1,1'b0,1'b0,8'h12,1'b1,3,5,2,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00};
    vecs[11] = '{1'b0,1'b1,1'b0,1'b0,8'h13,1'b1,4,6,2,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00};
    vecs[12] = '{1'b0,1'b1,1'b0,1'b0,8'h14,1'b1,5,7,2,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00};
    vecs[13] = '{1'b1,1'b1,1'b1,1'b0,8'h55,1'b0,0,0,0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00};
    vecs[14] = '{1'b0,1'b0,1'b1,1'b0,8'h00,1'b0,0,0,0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,8'h00};
    vecs[15] = '{1'b0,1'b0,1'b1,1'b1,8'h00,1'b0,0,0,0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,8'h00};
    vecs[16] = '{1'b0,1'b0,1'b0,1'b1,8'h00,1'b0,0,0,0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00};

    @(posedge clk);
    #1;

    $display("[TB] table: basic push/pop, empty corner cases, reset mid-stream");
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].psh, vecs[i].pp, vecs[i].clr, vecs[i].din, vecs[i].wen);
      checkOutput($sformatf("v%0d count", i),     count,     vecs[i].cnt);
      checkOutput($sformatf("v%0d waddr", i),     ram_waddr, vecs[i].wa);
      checkOutput($sformatf("v%0d raddr", i),     ram_raddr, vecs[i].ra);
      checkOutput($sformatf("v%0d rd_valid", i),  rd_valid,  vecs[i].rv);
      checkOutput($sformatf("v%0d empty", i),     empty,     vecs[i].emp);
      checkOutput($sformatf("v%0d full", i),      full,      vecs[i].ful);
      checkOutput($sformatf("v%0d overflow", i),  overflow,  vecs[i].ovf);
      checkOutput($sformatf("v%0d underflow", i), underflow, vecs[i].unf);
      if (vecs[i].chk) checkOutput($sformatf("v%0d data", i), data_out, vecs[i].dat);
    end

    $display("[TB] fill to full, overflow, drain in order");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'(i), 1'b1);
      checkOutput($sformatf("fill%0d count", i),       count,       i + 1);
      checkOutput($sformatf("fill%0d almost_full", i), almost_full, (i >= 11) ? 1 : 0);
      checkOutput($sformatf("fill%0d full", i),        full,        (i == 15) ? 1 : 0);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'hEE, 1'b0);
    checkOutput("push17 count",    count,     16);
    checkOutput("push17 overflow", overflow,  1);
    checkOutput("push17 waddr",    ram_waddr, 0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      checkOutput($sformatf("drain%0d rd_valid", i), rd_valid, 1);
      checkOutput($sformatf("drain%0d data", i),     data_out, i);
      checkOutput($sformatf("drain%0d count", i),    count,    15 - i);
    end
    checkOutput("drain empty",    empty,    1);
    checkOutput("drain overflow", overflow, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("reset clears overflow", overflow, 0);

    $display("[TB] streaming with pointer wrap");
    n_in  = 0;
    n_out = 0;
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 8; k++) begin
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'(n_in + 8'h20), 1'b1);
        n_in++;
        checkOutput("stream waddr", ram_waddr, n_in % 16);
        checkOutput("stream count", count,     k + 1);
        checkOutput("stream full",  full,      0);
      end
      for (int k = 0; k < 8; k++) begin
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput("stream data",  data_out,  n_out + 8'h20);
        n_out++;
        checkOutput("stream raddr", ram_raddr, n_out % 16);
        checkOutput("stream empty", empty,     (k == 7) ? 1 : 0);
      end
    end

    $display("[TB] simultaneous push and pop on a full FIFO");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'(8'h80 + i), 1'b1);
    checkOutput("full before swap", full, 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'hAA, 1'b1);
    checkOutput("swap count",    count,     16);
    checkOutput("swap rd_valid", rd_valid,  1);
    checkOutput("swap data",     data_out,  8'h80);
    checkOutput("swap waddr",    ram_waddr, 1);
    checkOutput("swap raddr",    ram_raddr, 1);
    checkOutput("swap overflow", overflow,  0);
    for (int i = 1; i < 17; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      checkOutput($sformatf("swapdrain%0d data", i), data_out, (i == 16) ? 8'hAA : 8'(8'h80 + i));
    end
    checkOutput("swapdrain empty", empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
